// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
// Module      : video_pkg
// Description : Shared constants, command encodings and blitter state type
//               for the text/colour VRAM fill/scroll engine.
// Revision    : 1.0 - initial release
// ============================================================================
package video_pkg;

  localparam int COLS      = 40;
  localparam int ROWS      = 25;
  localparam int PLANE_BIT = 10;

  localparam logic OP_FILL      = 1'b0;
  localparam logic OP_SCROLL_UP = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_VB    = 3'd1,
    ST_FILL_WR    = 3'd2,
    ST_SC_RD      = 3'd3,
    ST_SC_LAT     = 3'd4,
    ST_SC_WR      = 3'd5,
    ST_NEXT_PLANE = 3'd6,
    ST_DONE       = 3'd7
  } blit_state_e;

endpackage
`default_nettype wire

// File: rtl/vram_port_arb.sv
`default_nettype none
// ============================================================================
// Module      : vram_port_arb
// Description : Combinational CPU/blitter mux onto the VRAM host port. The CPU
//               always wins; grant_o tells the blitter its cycle counted.
// Revision    : 1.0 - initial release
// ============================================================================
module vram_port_arb (
  input  logic        cpu_en_i,
  input  logic [10:0] cpu_addr_i,
  input  logic [7:0]  cpu_wrdata_i,
  input  logic        cpu_wren_i,
  input  logic [10:0] blt_addr_i,
  input  logic [7:0]  blt_wrdata_i,
  input  logic        blt_wren_i,
  output logic [10:0] vram_addr_o,
  output logic [7:0]  vram_wrdata_o,
  output logic        vram_wren_o,
  output logic        grant_o
);

  always_comb begin
    if (cpu_en_i) begin
      vram_addr_o   = cpu_addr_i;
      vram_wrdata_o = cpu_wrdata_i;
      vram_wren_o   = cpu_wren_i;
    end else begin
      vram_addr_o   = blt_addr_i;
      vram_wrdata_o = blt_wrdata_i;
      vram_wren_o   = blt_wren_i;
    end
  end

  assign grant_o = ~cpu_en_i;

endmodule
`default_nettype wire

// File: rtl/text_blitter.sv
`default_nettype none
// ============================================================================
// Module      : text_blitter
// Description : Fill / scroll-up engine for the 40x25 text and colour VRAM,
//               running on cycles the CPU leaves idle.
// Revision    : 1.0 - initial release
// ============================================================================
module text_blitter #(
  parameter int COLS = video_pkg::COLS,
  parameter int ROWS = video_pkg::ROWS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] cpu_addr,
  input  logic [7:0]  cpu_wrdata,
  input  logic        cpu_en,
  input  logic        cpu_wren,
  output logic [7:0]  cpu_rddata,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_op,
  input  logic [1:0]  cmd_planes,
  input  logic [7:0]  cmd_fill,
  input  logic [4:0]  cmd_row_first,
  input  logic [4:0]  cmd_row_last,
  input  logic        cmd_vsync,
  input  logic        vblank,
  output logic        busy,
  output logic        done,
  output logic [10:0] vram_addr,
  output logic [7:0]  vram_wrdata,
  output logic        vram_wren,
  input  logic [7:0]  vram_rddata
);

  import video_pkg::*;

  localparam logic [9:0] COLS_W = 10'(COLS);
  localparam logic [4:0] ROWS_W = 5'(ROWS);

  function automatic logic [9:0] row_base(input logic [4:0] row);
    return {5'd0, row} * COLS_W;
  endfunction

  blit_state_e state_q, state_d;
  logic        op_q;
  logic [1:0]  planes_q;
  logic [7:0]  fill_q;
  logic [4:0]  first_q, last_q;
  logic        plane_q, plane_d;
  logic [9:0]  off_q, off_d;
  logic [7:0]  hold_q, hold_d;
  logic        busy_q, done_q, ready_q;

  logic        w_idle, w_accept, w_invalid, w_grant;
  logic        w_src_op;
  logic [1:0]  w_src_planes;
  logic [4:0]  w_src_first, w_src_last;
  blit_state_e w_start_state;
  logic [9:0]  w_start_off, w_fill_end, w_copy_end, w_blt_off;
  logic [10:0] w_blt_addr;
  logic [7:0]  w_blt_wrdata;
  logic        w_blt_wren;

  assign w_idle   = (state_q == ST_IDLE);
  assign w_accept = cmd_valid && ready_q;

  assign w_invalid = (cmd_row_first > cmd_row_last) || (cmd_row_last >= ROWS_W) ||
                     (cmd_planes == 2'b00);

  // Start parameters come straight from the command port on the accept
  // cycle so the first write lands on the very next edge.
  assign w_src_op     = w_idle ? cmd_op        : op_q;
  assign w_src_planes = w_idle ? cmd_planes    : planes_q;
  assign w_src_first  = w_idle ? cmd_row_first : first_q;
  assign w_src_last   = w_idle ? cmd_row_last  : last_q;

  assign w_start_state = ((w_src_op != OP_FILL) && (w_src_first != w_src_last)) ?
                         ST_SC_RD : ST_FILL_WR;
  assign w_start_off   = row_base(w_src_first);
  assign w_fill_end    = row_base(last_q) + COLS_W - 10'd1;
  assign w_copy_end    = row_base(last_q) - 10'd1;

  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    plane_d = plane_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          off_d   = w_start_off;
          plane_d = ~w_src_planes[0];
          if (w_invalid)      state_d = ST_DONE;
          else if (cmd_vsync) state_d = ST_WAIT_VB;
          else                state_d = w_start_state;
        end
      end
      ST_WAIT_VB: begin
        if (vblank) state_d = w_start_state;
      end
      ST_FILL_WR: begin
        if (w_grant) begin
          if (off_q == w_fill_end) begin
            state_d = (!plane_q && planes_q[1]) ? ST_NEXT_PLANE : ST_DONE;
          end else begin
            off_d = off_q + 10'd1;
          end
        end
      end
      ST_SC_RD: begin
        if (w_grant) state_d = ST_SC_LAT;
      end
      ST_SC_LAT: begin
        // Read data is only valid this one cycle, so capture regardless of CPU.
        hold_d  = vram_rddata;
        state_d = ST_SC_WR;
      end
      ST_SC_WR: begin
        if (w_grant) begin
          off_d   = off_q + 10'd1;
          state_d = (off_q == w_copy_end) ? ST_FILL_WR : ST_SC_RD;
        end
      end
      ST_NEXT_PLANE: begin
        plane_d = 1'b1;
        off_d   = w_start_off;
        state_d = w_start_state;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_FILL;
      planes_q <= 2'b00;
      fill_q   <= 8'h00;
      first_q  <= 5'd0;
      last_q   <= 5'd0;
      plane_q  <= 1'b0;
      off_q    <= 10'd0;
      hold_q   <= 8'h00;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      plane_q <= plane_d;
      off_q   <= off_d;
      hold_q  <= hold_d;
      if (w_accept) begin
        op_q     <= cmd_op;
        planes_q <= cmd_planes;
        fill_q   <= cmd_fill;
        first_q  <= cmd_row_first;
        last_q   <= cmd_row_last;
      end
      busy_q  <= (state_d != ST_IDLE) && (state_d != ST_DONE);
      done_q  <= (state_d == ST_DONE);
      ready_q <= (state_d == ST_IDLE);
    end
  end

  assign w_blt_off = (state_q == ST_SC_RD) ? (off_q + COLS_W) : off_q;

  always_comb begin
    w_blt_addr            = {1'b0, w_blt_off};
    w_blt_addr[PLANE_BIT] = plane_q;
  end

  assign w_blt_wrdata = (state_q == ST_SC_WR) ? hold_q : fill_q;
  // Gating with reset keeps an in-flight write from landing on the abort edge.
  assign w_blt_wren   = reset && ((state_q == ST_FILL_WR) || (state_q == ST_SC_WR));

  vram_port_arb u_arb (
    .cpu_en_i      (cpu_en),
    .cpu_addr_i    (cpu_addr),
    .cpu_wrdata_i  (cpu_wrdata),
    .cpu_wren_i    (cpu_wren),
    .blt_addr_i    (w_blt_addr),
    .blt_wrdata_i  (w_blt_wrdata),
    .blt_wren_i    (w_blt_wren),
    .vram_addr_o   (vram_addr),
    .vram_wrdata_o (vram_wrdata),
    .vram_wren_o   (vram_wren),
    .grant_o       (w_grant)
  );

  assign cpu_rddata = vram_rddata;
  assign busy       = busy_q;
  assign done       = done_q;
  assign cmd_ready  = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_text_blitter.sv
`default_nettype none
// ============================================================================
// Module      : tb_text_blitter
// Description : Directed self-checking bench for text_blitter with a VRAM
//               model standing in for the video stage host port.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_text_blitter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [10:0] cpu_addr = '0;
  logic [7:0]  cpu_wrdata = '0;
  logic        cpu_en = 1'b0;
  logic        cpu_wren = 1'b0;
  logic [7:0]  cpu_rddata;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_op = 1'b0;
  logic [1:0]  cmd_planes = '0;
  logic [7:0]  cmd_fill = '0;
  logic [4:0]  cmd_row_first = '0;
  logic [4:0]  cmd_row_last = '0;
  logic        cmd_vsync = 1'b0;
  logic        vblank = 1'b0;
  logic        busy, done;
  logic [10:0] vram_addr;
  logic [7:0]  vram_wrdata;
  logic        vram_wren;
  logic [7:0]  vram_rddata;

  always #5 clk = ~clk;

  text_blitter dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_wrdata(cpu_wrdata), .cpu_en(cpu_en),
    .cpu_wren(cpu_wren), .cpu_rddata(cpu_rddata),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_planes(cmd_planes), .cmd_fill(cmd_fill),
    .cmd_row_first(cmd_row_first), .cmd_row_last(cmd_row_last),
    .cmd_vsync(cmd_vsync), .vblank(vblank), .busy(busy), .done(done),
    .vram_addr(vram_addr), .vram_wrdata(vram_wrdata), .vram_wren(vram_wren),
    .vram_rddata(vram_rddata)
  );

  // Video-stage VRAM: synchronous write, 1-cycle read latency.
  logic [7:0] mem [0:2047];
  logic [7:0] shadow [0:2047];
  logic [7:0] rd_q;
  bit         mem_ready;

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 8'hC3;
      mem_ready <= 1'b1;
    end else begin
      if (vram_wren) mem[vram_addr] <= vram_wrdata;
      rd_q <= mem[vram_addr];
    end
  end
  assign vram_rddata = rd_q;

  // Activity monitor sampled mid-cycle.
  logic clr = 1'b0;
  int   cyc = 0, wr_cnt = 0, done_cnt = 0;
  int   first_wr = -1, last_wr = -1, done_cyc = -1, acc_cyc = -1;
  int   last_txt = -1, first_col = -1;

  always @(negedge clk) begin
    cyc++;
    if (clr) begin
      wr_cnt = 0; done_cnt = 0; first_wr = -1; last_wr = -1;
      done_cyc = -1; acc_cyc = -1; last_txt = -1; first_col = -1;
    end else begin
      if (cmd_valid && cmd_ready) acc_cyc = cyc;
      if (vram_wren && !cpu_en) begin
        if (wr_cnt == 0) first_wr = cyc;
        wr_cnt++;
        last_wr = cyc;
        if (vram_addr[10]) begin
          if (first_col < 0) first_col = cyc;
        end else begin
          last_txt = cyc;
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic issue(input logic op, input logic [1:0] planes, input logic [7:0] fill,
                       input logic [4:0] first, input logic [4:0] last, input logic vs);
    cmd_op = op; cmd_planes = planes; cmd_fill = fill;
    cmd_row_first = first; cmd_row_last = last; cmd_vsync = vs;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string tag);
    int n = 0;
    while (done_cnt == 0 && n < limit) begin
      tick();
      n++;
    end
    check(tag, done_cnt > 0, 1);
    repeat (3) tick();
  endtask

  task automatic cpu_wr(input logic [10:0] a, input logic [7:0] d);
    cpu_en = 1'b1; cpu_wren = 1'b1; cpu_addr = a; cpu_wrdata = d;
    tick();
    cpu_en = 1'b0; cpu_wren = 1'b0;
    shadow[a] = d;
  endtask

  task automatic img_check(input string tag);
    int bad = 0;
    for (int i = 0; i < 2048; i++) if (mem[i] !== shadow[i]) bad++;
    check(tag, bad, 0);
  endtask

  initial begin
    int n;
    int k;
    int vb_cyc;
    for (int i = 0; i < 2048; i++) shadow[i] = 8'hC3;

    repeat (3) tick();
    reset = 1'b1;
    repeat (2) tick();
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wren", vram_wren, 0);

    // FILL whole text plane with spaces.
    clear_mon();
    issue(1'b0, 2'b01, 8'h20, 5'd0, 5'd24, 1'b0);
    check("fill_busy", busy, 1);
    wait_done(1200, "fill_timeout");
    check("fill_count", wr_cnt, 1000);
    check("fill_first", first_wr, acc_cyc + 1);
    check("fill_last", last_wr, acc_cyc + 1000);
    check("fill_done_cyc", done_cyc, last_wr + 1);
    check("fill_done_once", done_cnt, 1);
    for (int i = 0; i < 1000; i++) shadow[i] = 8'h20;
    img_check("fill_image");
    check("fill_idle_ready", cmd_ready, 1);

    // Preload text row r with r, then scroll rows 2..5 up.
    for (int r = 0; r < 25; r++)
      for (int c = 0; c < 40; c++) cpu_wr(11'(r * 40 + c), 8'(r));
    clear_mon();
    issue(1'b1, 2'b01, 8'h00, 5'd2, 5'd5, 1'b0);
    wait_done(700, "scroll_timeout");
    check("scroll_count", wr_cnt, 160);
    check("scroll_first", first_wr, acc_cyc + 3);
    check("scroll_done_cyc", done_cyc, acc_cyc + 401);
    for (int r = 2; r < 5; r++)
      for (int c = 0; c < 40; c++) shadow[r * 40 + c] = 8'(r + 1);
    for (int c = 0; c < 40; c++) shadow[200 + c] = 8'h00;
    img_check("scroll_image");

    // Two-plane fill of row 3 with the CPU active every other cycle.
    clear_mon();
    issue(1'b0, 2'b11, 8'h5A, 5'd3, 5'd3, 1'b0);
    n = 0;
    k = 0;
    while (done_cnt == 0 && n < 400) begin
      cpu_en = (n % 2 == 0);
      cpu_wren = cpu_en;
      if (cpu_en) begin
        cpu_addr = 11'h400 + 11'(600 + k);
        cpu_wrdata = 8'(8'h80 + k);
        shadow[11'h400 + 11'(600 + k)] = 8'(8'h80 + k);
        k++;
      end
      tick();
      n++;
    end
    cpu_en = 1'b0;
    cpu_wren = 1'b0;
    check("share_timeout", done_cnt > 0, 1);
    repeat (3) tick();
    check("share_count", wr_cnt, 80);
    check("share_order", last_txt < first_col, 1);
    check("share_done_cyc", done_cyc, last_wr + 1);
    for (int c = 0; c < 40; c++) begin
      shadow[120 + c] = 8'h5A;
      shadow[1024 + 120 + c] = 8'h5A;
    end
    img_check("share_image");
    cpu_en = 1'b1; cpu_addr = 11'h400 + 11'd600;
    tick();
    cpu_en = 1'b0;
    check("cpu_read", cpu_rddata, 8'h80);

    // Vsync wait: nothing happens until vblank.
    vblank = 1'b0;
    clear_mon();
    issue(1'b0, 2'b01, 8'h11, 5'd0, 5'd0, 1'b1);
    repeat (100) tick();
    check("vs_no_writes", wr_cnt, 0);
    check("vs_busy", busy, 1);
    vblank = 1'b1;
    vb_cyc = cyc;
    wait_done(100, "vs_timeout");
    vblank = 1'b0;
    check("vs_first", first_wr, vb_cyc + 2);
    check("vs_count", wr_cnt, 40);
    for (int c = 0; c < 40; c++) shadow[c] = 8'h11;
    img_check("vs_image");

    // Invalid commands: reversed range, row past the end, no planes.
    for (int v = 0; v < 3; v++) begin
      clear_mon();
      case (v)
        0:       issue(1'b0, 2'b01, 8'hEE, 5'd10, 5'd4, 1'b0);
        1:       issue(1'b1, 2'b11, 8'hEE, 5'd20, 5'd25, 1'b0);
        default: issue(1'b0, 2'b00, 8'hEE, 5'd1, 5'd2, 1'b0);
      endcase
      wait_done(10, "inv_timeout");
      check("inv_writes", wr_cnt, 0);
      check("inv_done_cyc", done_cyc, acc_cyc + 1);
      check("inv_done_once", done_cnt, 1);
    end
    img_check("inv_image");

    // Reset during a fill after 10 writes.
    clear_mon();
    issue(1'b0, 2'b01, 8'h77, 5'd0, 5'd24, 1'b0);
    n = 0;
    while (wr_cnt < 10 && n < 50) begin
      tick();
      n++;
    end
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    repeat (20) tick();
    check("abort_writes", wr_cnt, 10);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_ready", cmd_ready, 1);
    check("abort_no_done", done_cnt, 0);
    for (int c = 0; c < 10; c++) shadow[c] = 8'h77;
    img_check("abort_image");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
